// File: rtl/conv_wr_ctrl_if.sv
// conv_wr_ctrl bus interface: IFFT input stream, write requests, completions.
// master = write controller, slave = upstream/host side.
interface conv_wr_ctrl_if #(
  parameter int ADDR_LMT    = 20,
  parameter int MDATA       = 14,
  parameter int CACHE_WIDTH = 512
);
  logic                   in_valid;
  logic [CACHE_WIDTH-1:0] in_data;
  logic                   in_almostfull;
  logic [ADDR_LMT-1:0]    wr_req_addr;
  logic [MDATA-1:0]       wr_req_mdata;
  logic [CACHE_WIDTH-1:0] wr_req_data;
  logic                   wr_req_en;
  logic                   wr_req_almostfull;
  logic                   wr_rsp0_valid;
  logic                   wr_rsp1_valid;

  modport master (
    input  in_valid,
    input  in_data,
    output in_almostfull,
    output wr_req_addr,
    output wr_req_mdata,
    output wr_req_data,
    output wr_req_en,
    input  wr_req_almostfull,
    input  wr_rsp0_valid,
    input  wr_rsp1_valid
  );

  modport slave (
    output in_valid,
    output in_data,
    input  in_almostfull,
    input  wr_req_addr,
    input  wr_req_mdata,
    input  wr_req_data,
    input  wr_req_en,
    output wr_req_almostfull,
    output wr_rsp0_valid,
    output wr_rsp1_valid
  );
endinterface

// File: rtl/conv_wr_ctrl.sv
// Write controller: buffers IFFT cachelines and issues addressed write requests.
// Optional WR_CTRL_PERF_EN adds a saturating stall_cycles counter output.
module conv_wr_ctrl #(
  parameter int ADDR_LMT    = 20,
  parameter int MDATA       = 14,
  parameter int CACHE_WIDTH = 512,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADDR_LMT-1:0] dest_base_addr,
  input  logic [31:0]         num_cl_out,
  conv_wr_ctrl_if.master      bus,
  output logic                done,
  output logic                overflow
`ifdef WR_CTRL_PERF_EN
  ,
  output logic [31:0]         stall_cycles
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW-1:0] P_ONE  = PW'(1);
  localparam logic [PW:0]   C_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   C_FULL = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0]   C_AF   = (PW+1)'(FIFO_DEPTH - 4);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [ADDR_LMT-1:0]    r_base;
  logic [31:0]            r_num;
  logic [31:0]            r_issued;
  logic [32:0]            r_resp;
  logic [32:0]            w_resp_nxt;

  logic [CACHE_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]          r_wptr;
  logic [PW-1:0]          r_rptr;
  logic [PW:0]            r_count;

  logic                   r_req_en;
  logic [ADDR_LMT-1:0]    r_req_addr;
  logic [MDATA-1:0]       r_req_mdata;
  logic [CACHE_WIDTH-1:0] r_req_data;
  logic                   r_done;
  logic                   r_overflow;

  logic w_start_job;
  logic w_leave_run;
  logic w_run;
  logic w_full;
  logic w_push_req;
  logic w_push;
  logic w_pop;
  logic w_drop;

  assign w_run      = (r_state == S_RUN);
  assign w_full     = (r_count == C_FULL);
  assign w_pop      = w_run && (r_count != '0) &&
                      !bus.wr_req_almostfull &&
                      (r_issued < r_num);
  assign w_push_req = w_run && bus.in_valid;
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && w_full && !w_pop;
  assign w_resp_nxt = r_resp +
                      33'(bus.wr_rsp0_valid) +
                      33'(bus.wr_rsp1_valid);

  // Next-state and job control decode
  always_comb begin
    w_state_nxt = r_state;
    w_start_job = 1'b0;
    w_leave_run = 1'b0;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_start_job = 1'b1;
          w_state_nxt = (num_cl_out == 32'd0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (r_issued == r_num) begin
          w_leave_run = 1'b1;
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_resp_nxt >= {1'b0, r_num}) begin
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Job configuration and issue/response counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_base   <= '0;
      r_num    <= '0;
      r_issued <= '0;
      r_resp   <= '0;
    end else if (w_start_job) begin
      r_base   <= dest_base_addr;
      r_num    <= num_cl_out;
      r_issued <= '0;
      r_resp   <= '0;
    end else begin
      if (w_pop) begin
        r_issued <= r_issued + 32'd1;
      end
      if (w_run || (r_state == S_DRAIN)) begin
        r_resp <= w_resp_nxt;
      end
    end
  end

  // Buffer storage; emptiness is tracked by the pointers, not the array
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= bus.in_data;
    end
  end

  // Buffer pointers and occupancy; flushed when a job starts or RUN ends
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (w_start_job || w_leave_run) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + P_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + P_ONE;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_ONE;
        2'b01:   r_count <= r_count - C_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Registered write-request outputs; fields hold between pops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_req_en    <= 1'b0;
      r_req_addr  <= '0;
      r_req_mdata <= '0;
      r_req_data  <= '0;
    end else begin
      r_req_en <= w_pop;
      if (w_pop) begin
        r_req_addr  <= r_base + r_issued[ADDR_LMT-1:0];
        r_req_mdata <= r_issued[MDATA-1:0];
        r_req_data  <= r_mem[r_rptr];
      end
    end
  end

  // Done level and sticky overflow (drop, or leftovers discarded)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else if (w_start_job) begin
      r_done     <= (num_cl_out == 32'd0);
      r_overflow <= 1'b0;
    end else begin
      if ((r_state == S_DRAIN) && (w_state_nxt == S_DONE)) begin
        r_done <= 1'b1;
      end
      if (w_drop ||
          (w_leave_run && ((r_count != '0) || w_push))) begin
        r_overflow <= 1'b1;
      end
    end
  end

`ifdef WR_CTRL_PERF_EN
  logic [31:0] r_stall;

  // Cycles with data waiting but downstream throttled, saturating
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall <= '0;
    end else if (w_start_job) begin
      r_stall <= '0;
    end else if (w_run && (r_count != '0) &&
                 bus.wr_req_almostfull &&
                 (r_stall != '1)) begin
      r_stall <= r_stall + 32'd1;
    end
  end

  assign stall_cycles = r_stall;
`endif

  assign bus.in_almostfull = (r_count >= C_AF);
  assign bus.wr_req_en     = r_req_en;
  assign bus.wr_req_addr   = r_req_addr;
  assign bus.wr_req_mdata  = r_req_mdata;
  assign bus.wr_req_data   = r_req_data;
  assign done              = r_done;
  assign overflow          = r_overflow;

endmodule
